rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Owns the single write port of the 8-bit register file (wr_en / movInstr / addrA / dat_in).
- After reset, and on request, it sequences a clear of every register.
- It then shares the write port between two requesters, A (core writeback) and B (load/aux unit), using round-robin arbitration and valid/ready handshakes.
- Outputs are registered and drive the register file write inputs directly. Read ports are not touched.

Parameters:
PW, 3, pointer width parameter matching the register file: address ports are PW+1 bits wide, depth is 2**PW entries
INIT_VAL, 8'h00, value written to every register during an init sweep

Ports:
clk  in  1  system clock; all state changes on posedge
rst_n  in  1  asynchronous, active-low reset
init_req  in  1  single-cycle pulse in RUN; restarts the clear sweep
a_valid  in  1  requester A has a write pending
a_ready  out  1  A's write is accepted this cycle (combinational)
a_mov  in  1  A's movInstr flag (0 = write targets r0)
a_addr  in  PW+1  A's target register
a_data  in  8  A's write data
b_valid, b_ready, b_mov, b_addr, b_data: same as the A ports, for requester B
rf_wr_en  out  1  register file write enable (registered)
rf_mov  out  1  register file movInstr (registered)
rf_addr  out  PW+1  register file addrA (registered)
rf_dat  out  8  register file dat_in (registered)
init_done  out  1  1 while in RUN
err_oob  out  1  one-cycle pulse: accepted address >= 2**PW
last_grant  out  1  0 = A was granted last, 1 = B was granted last

Behaviour:
- Reset (async assert, any state):
  - state = INIT, cnt = 0, ptr = A.
  - rf_wr_en = 0, rf_mov = 0, rf_addr = 0, rf_dat = 0.
  - init_done = 0, err_oob = 0, last_grant = 0.
  - a_ready = b_ready = 0.
- INIT state:
  - Each posedge registers rf_wr_en=1, rf_mov=1, rf_addr=cnt, rf_dat=INIT_VAL.
  - If cnt == 2**PW-1: state <= RUN, init_done <= 1, cnt <= 0. Otherwise cnt <= cnt+1.
  - The sweep takes exactly 2**PW cycles: 8 at default, addresses 0..7 in order.
  - a_ready = b_ready = 0 throughout INIT; init_req is ignored.
- RUN state, arbitration (combinational, in the same cycle):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester ptr points to.
  - x_ready = 1 only for the granted requester. At most one ready is high per cycle.
  - Ready never asserts without the matching valid.
- RUN state, on an accepting posedge (valid & ready):
  - rf_wr_en <= 1 and rf_mov/rf_addr/rf_dat <= the granted requester's mov/addr/data.
  - ptr <= the non-granted requester; last_grant <= granted id.
  - Latency: accept at edge N, write presented on rf_* after edge N, register file commits at edge N+1.
- RUN state, no accept: rf_wr_en <= 0; rf_mov/rf_addr/rf_dat hold their previous values.
- Out-of-range address (addr >= 2**PW, i.e. MSB of addr set):
  - The request is still accepted (handshake completes) and ptr updates.
  - rf_wr_en <= 0 and err_oob <= 1 for one cycle; no write reaches the register file.
- mov=0 requests pass through unchanged; the register file redirects them to r0. The arbiter does not alter the address.
- init_req high in RUN:
  - Takes priority over any request: both readies are forced to 0 that cycle, so nothing is accepted.
  - At that posedge: state <= INIT, cnt <= 0, init_done <= 0, rf_wr_en <= 0.
  - The sweep starts on the next edge.
- Back-to-back accepts are allowed every cycle. With both requesters valid continuously, grants strictly alternate.
- Requesters must hold valid/addr/data stable until accepted. A dropped valid is not an error; nothing is buffered.
- Reset mid-sweep or mid-write: the in-flight write is abandoned (rf_wr_en = 0 immediately) and the sweep restarts from address 0 after release.

Test Plan:
1. Release rst_n, no requests -> rf_wr_en=1 for 8 consecutive cycles, rf_addr 0..7, rf_dat=00, rf_mov=1; init_done=1 after the 8th edge; readies 0 throughout.
2. RUN, only A valid (addr 3, data A5, mov 1) -> a_ready=1 same cycle; next cycle rf_wr_en=1, rf_addr=3, rf_dat=A5, last_grant=0; following cycle rf_wr_en=0.
3. RUN, A and B valid continuously for 6 cycles (ptr=A at start) -> grants A,B,A,B,A,B; never both readies high.
4. Accept B with addr 4'b1010 -> b_ready=1; next cycle err_oob=1, rf_wr_en=0; ptr moves to A.
5. init_req pulse with A valid -> a_ready=0 that cycle; 8-cycle sweep follows; A is accepted only once init_done=1.
6. Assert rst_n low at sweep address 5 for one cycle, then release -> outputs clear immediately; sweep restarts at address 0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the register file write port, clears it after reset or on request,
// then shares it round-robin between requesters A and B.
module rf_write_arbiter #(
    parameter int         PW       = 3,
    parameter logic [7:0] INIT_VAL = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_req,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_mov,
    input  logic [PW:0]   a_addr,
    input  logic [7:0]    a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_mov,
    input  logic [PW:0]   b_addr,
    input  logic [7:0]    b_data,
    output logic          rf_wr_en,
    output logic          rf_mov,
    output logic [PW:0]   rf_addr,
    output logic [7:0]    rf_dat,
    output logic          init_done,
    output logic          err_oob,
    output logic          last_grant
);
    typedef enum logic {INIT, RUN} state_t;

    state_t        state, state_n;
    logic [PW-1:0] cnt, cnt_n;
    logic          ptr, ptr_n;
    logic          wr_n, mov_n, done_n, oob_n, lg_n;
    logic [PW:0]   addr_n;
    logic [7:0]    dat_n;
    logic          run_ok, acc, g_mov;
    logic [PW:0]   g_addr;
    logic [7:0]    g_data;

    // ptr = 0 favours A, 1 favours B when both are valid
    assign run_ok  = (state == RUN) && !init_req;
    assign a_ready = run_ok && a_valid && (!b_valid || !ptr);
    assign b_ready = run_ok && b_valid && (!a_valid || ptr);
    assign acc     = a_ready || b_ready;
    assign g_mov   = b_ready ? b_mov  : a_mov;
    assign g_addr  = b_ready ? b_addr : a_addr;
    assign g_data  = b_ready ? b_data : a_data;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        wr_n    = 1'b0;
        mov_n   = rf_mov;
        addr_n  = rf_addr;
        dat_n   = rf_dat;
        done_n  = init_done;
        oob_n   = 1'b0;
        lg_n    = last_grant;
        if (state == INIT) begin
            wr_n   = 1'b1;
            mov_n  = 1'b1;
            addr_n = {1'b0, cnt};
            dat_n  = INIT_VAL;
            if (cnt == '1) begin
                state_n = RUN;
                done_n  = 1'b1;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end else if (init_req) begin
            state_n = INIT;
            cnt_n   = '0;
            done_n  = 1'b0;
        end else if (acc) begin
            // out-of-range targets complete the handshake but never reach the file
            mov_n  = g_mov;
            addr_n = g_addr;
            dat_n  = g_data;
            wr_n   = !g_addr[PW];
            oob_n  = g_addr[PW];
            ptr_n  = !b_ready;
            lg_n   = b_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            cnt        <= '0;
            ptr        <= 1'b0;
            rf_wr_en   <= 1'b0;
            rf_mov     <= 1'b0;
            rf_addr    <= '0;
            rf_dat     <= '0;
            init_done  <= 1'b0;
            err_oob    <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            rf_wr_en   <= wr_n;
            rf_mov     <= mov_n;
            rf_addr    <= addr_n;
            rf_dat     <= dat_n;
            init_done  <= done_n;
            err_oob    <= oob_n;
            last_grant <= lg_n;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed plan steps plus randomized traffic, checked every cycle
// against a behavioural model of the sweep and round-robin arbitration.
module tb_rf_write_arbiter;
    localparam int PW = 3;
    localparam int N  = 1 << PW;

    logic          clk = 0, rst_n = 1, init_req = 0;
    logic          a_valid = 0, a_mov = 0, b_valid = 0, b_mov = 0;
    logic [PW:0]   a_addr = 0, b_addr = 0;
    logic [7:0]    a_data = 0, b_data = 0;
    logic          a_ready, b_ready, rf_wr_en, rf_mov, init_done, err_oob, last_grant;
    logic [PW:0]   rf_addr;
    logic [7:0]    rf_dat;

    int n_cmp = 0, n_bad = 0;

    bit m_init, m_wr, m_mov, m_done, m_oob;
    int m_idx, m_ptr, m_lg, m_addr, m_dat, last_g;

    rf_write_arbiter #(.PW(PW), .INIT_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req),
        .a_valid(a_valid), .a_ready(a_ready), .a_mov(a_mov), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_mov(b_mov), .b_addr(b_addr), .b_data(b_data),
        .rf_wr_en(rf_wr_en), .rf_mov(rf_mov), .rf_addr(rf_addr), .rf_dat(rf_dat),
        .init_done(init_done), .err_oob(err_oob), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        if (!rst_n || m_init || init_req) return -1;
        if (a_valid && b_valid) return m_ptr;
        if (a_valid) return 0;
        if (b_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_init = 1; m_idx = 0; m_ptr = 0; m_lg = 0; last_g = -1;
        m_wr = 0; m_mov = 0; m_addr = 0; m_dat = 0; m_done = 0; m_oob = 0;
    endtask

    task automatic model_step();
        int g;
        g = exp_grant();
        last_g = g;
        m_oob = 0;
        if (m_init) begin
            m_wr = 1; m_mov = 1; m_addr = m_idx; m_dat = 0;
            if (m_idx == N - 1) begin m_init = 0; m_done = 1; m_idx = 0; end
            else m_idx++;
        end else if (init_req) begin
            m_init = 1; m_idx = 0; m_done = 0; m_wr = 0;
        end else if (g >= 0) begin
            m_mov  = (g == 0) ? a_mov : b_mov;
            m_addr = (g == 0) ? int'(a_addr) : int'(b_addr);
            m_dat  = (g == 0) ? int'(a_data) : int'(b_data);
            m_wr   = m_addr < N;
            m_oob  = m_addr >= N;
            m_ptr  = 1 - g;
            m_lg   = g;
        end else begin
            m_wr = 0;
        end
    endtask

    task automatic compare_all();
        int g;
        g = exp_grant();
        chk("a_ready", a_ready, g == 0);
        chk("b_ready", b_ready, g == 1);
        chk("rf_wr_en", rf_wr_en, m_wr);
        chk("err_oob", err_oob, m_oob);
        chk("init_done", init_done, m_done);
        chk("last_grant", last_grant, m_lg);
        if (m_wr) begin
            chk("rf_addr", rf_addr, m_addr);
            chk("rf_dat", rf_dat, m_dat);
            chk("rf_mov", rf_mov, m_mov);
        end
    endtask

    task automatic tick();
        #1 compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_wr_en", rf_wr_en, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_oob", err_oob, 0);
        chk("rst_addr", rf_addr, 0);
        chk("rst_last_grant", last_grant, 0);
        chk("rst_ready", a_ready | b_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [PW:0] rand_addr();
        return ($urandom_range(3) == 0) ? (PW+1)'(N + $urandom_range(N-1)) : (PW+1)'($urandom_range(N-1));
    endfunction

    initial begin
        #2 do_reset();
        // sweep after reset
        for (int k = 0; k < N; k++) begin
            tick();
            chk("sweep_addr", rf_addr, k);
            chk("sweep_wr", rf_wr_en, 1);
            chk("sweep_dat", rf_dat, 0);
        end
        chk("sweep_done", init_done, 1);
        // single A write
        a_valid = 1; a_addr = 3; a_data = 8'hA5; a_mov = 1;
        #1 chk("a_only_ready", a_ready, 1);
        tick();
        a_valid = 0;
        chk("a_only_wr", rf_wr_en, 1);
        chk("a_only_addr", rf_addr, 3);
        chk("a_only_dat", rf_dat, 8'hA5);
        chk("a_only_lg", last_grant, 0);
        tick();
        chk("a_only_idle", rf_wr_en, 0);
        // out-of-range B write, leaves ptr on A
        b_valid = 1; b_addr = 4'b1010; b_data = 8'h3C; b_mov = 1;
        #1 chk("oob_ready", b_ready, 1);
        tick();
        b_valid = 0;
        chk("oob_flag", err_oob, 1);
        chk("oob_wr", rf_wr_en, 0);
        chk("oob_lg", last_grant, 1);
        tick();
        chk("oob_pulse", err_oob, 0);
        // alternation with both valid
        a_valid = 1; b_valid = 1; a_addr = 1; b_addr = 2; a_data = 8'h10; b_data = 8'h20;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("alt_a", a_ready, (i % 2) == 0);
            chk("alt_b", b_ready, (i % 2) == 1);
            tick();
            a_data++; b_data++;
        end
        a_valid = 0; b_valid = 0;
        tick();
        // init_req wins over a pending A request
        a_valid = 1; a_addr = 2; a_data = 8'h11; a_mov = 0; init_req = 1;
        #1 chk("init_req_block", a_ready, 0);
        tick();
        init_req = 0;
        for (int k = 0; k < N; k++) tick();
        chk("resweep_done", init_done, 1);
        #1 chk("post_sweep_accept", a_ready, 1);
        tick();
        a_valid = 0;
        chk("post_sweep_addr", rf_addr, 2);
        chk("post_sweep_dat", rf_dat, 8'h11);
        chk("post_sweep_mov", rf_mov, 0);
        // reset mid-sweep at address 5
        init_req = 1;
        tick();
        init_req = 0;
        for (int k = 0; k < 6; k++) tick();
        chk("mid_sweep_addr", rf_addr, 5);
        do_reset();
        tick();
        chk("restart_addr", rf_addr, 0);
        chk("restart_wr", rf_wr_en, 1);
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (a_valid && (last_g == 0 || $urandom_range(15) == 0)) a_valid = 0;
            if (b_valid && (last_g == 1 || $urandom_range(15) == 0)) b_valid = 0;
            if (!a_valid && $urandom_range(1) == 1) begin
                a_valid = 1; a_mov = 1'($urandom); a_addr = rand_addr(); a_data = 8'($urandom);
            end
            if (!b_valid && $urandom_range(1) == 1) begin
                b_valid = 1; b_mov = 1'($urandom); b_addr = rand_addr(); b_data = 8'($urandom);
            end
            init_req = ($urandom_range(59) == 0);
            if ($urandom_range(799) == 0) do_reset();
            else tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
